// File: rtl/test_pattern_sequencer.sv
// test_pattern_sequencer: frame-synchronous driver for the test pattern
// generator's pattern select. It steps through FIRST_PATTERN..LAST_PATTERN,
// dwelling FRAMES_PER_PATTERN frames on each. A level req/ack handshake
// gives a manual override. Every change lands on a VSync rising edge, so
// frames are never torn.
// Optional feature: define TPSEQ_FRAME_COUNT_EN to add o_Frame_Count, a
// 16-bit wrapping count of frame starts since reset.
module test_pattern_sequencer #(
    parameter int FRAMES_PER_PATTERN = 60,
    parameter int FIRST_PATTERN      = 1,
    parameter int LAST_PATTERN       = 7
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_VSync,
    input  logic       i_Enable,
    input  logic       i_Manual_Req,
    input  logic [3:0] i_Manual_Pattern,
    output logic [3:0] o_Pattern,
    output logic       o_Frame_Start,
    output logic       o_Manual_Ack,
    output logic [1:0] o_State
`ifdef TPSEQ_FRAME_COUNT_EN
    ,
    output logic [15:0] o_Frame_Count
`endif
);

    localparam int CW = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAMES_PER_PATTERN - 1);
    localparam logic [3:0]    FIRST_P  = 4'(FIRST_PATTERN);
    localparam logic [3:0]    LAST_P   = 4'(LAST_PATTERN);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_AUTO   = 2'b01,
        ST_MANUAL = 2'b10
    } state_e;

    state_e        state_q,       state_d;
    logic [3:0]    pattern_q,     pattern_d;
    logic [3:0]    index_q,       index_d;
    logic [CW-1:0] cnt_q,         cnt_d;
    logic          ack_q,         ack_d;
    logic          frame_start_q, frame_start_d;
    // Delayed VSync; resets high so a VSync already high at release is not an edge.
    logic          vsync_q,       vsync_d;
    logic          w_fs;
`ifdef TPSEQ_FRAME_COUNT_EN
    logic [15:0]   fcount_q,      fcount_d;
`endif

    assign w_fs = i_VSync & ~vsync_q;

    // Next-state: requests are only looked at on a frame start; otherwise hold.
    always_comb begin
        vsync_d       = i_VSync;
        frame_start_d = w_fs;
        state_d       = state_q;
        pattern_d     = pattern_q;
        index_d       = index_q;
        cnt_d         = cnt_q;
        ack_d         = ack_q;
`ifdef TPSEQ_FRAME_COUNT_EN
        fcount_d      = w_fs ? fcount_q + 16'd1 : fcount_q;
`endif
        if (w_fs) begin
            if (!i_Enable) begin
                // Saved index kept so a later MANUAL->AUTO can resume it.
                state_d   = ST_IDLE;
                pattern_d = 4'd0;
                ack_d     = 1'b0;
                cnt_d     = '0;
            end else if (i_Manual_Req) begin
                state_d   = ST_MANUAL;
                pattern_d = i_Manual_Pattern;
                ack_d     = 1'b1;
                cnt_d     = '0;
            end else begin
                state_d = ST_AUTO;
                ack_d   = 1'b0;
                case (state_q)
                    ST_IDLE: begin
                        index_d = FIRST_P;
                        cnt_d   = '0;
                    end
                    ST_AUTO: begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_d   = '0;
                            index_d = (index_q == LAST_P) ? FIRST_P : index_q + 4'd1;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    // Back from MANUAL: full dwell on the saved index.
                    default: cnt_d = '0;
                endcase
                pattern_d = index_d;
            end
        end
    end

    // State and output registers; reset has priority over a same-cycle frame start.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q       <= ST_IDLE;
            pattern_q     <= 4'd0;
            index_q       <= FIRST_P;
            cnt_q         <= '0;
            ack_q         <= 1'b0;
            frame_start_q <= 1'b0;
            vsync_q       <= 1'b1;
`ifdef TPSEQ_FRAME_COUNT_EN
            fcount_q      <= 16'd0;
`endif
        end else begin
            state_q       <= state_d;
            pattern_q     <= pattern_d;
            index_q       <= index_d;
            cnt_q         <= cnt_d;
            ack_q         <= ack_d;
            frame_start_q <= frame_start_d;
            vsync_q       <= vsync_d;
`ifdef TPSEQ_FRAME_COUNT_EN
            fcount_q      <= fcount_d;
`endif
        end
    end

    assign o_Pattern     = pattern_q;
    assign o_Frame_Start = frame_start_q;
    assign o_Manual_Ack  = ack_q;
    assign o_State       = state_q;
`ifdef TPSEQ_FRAME_COUNT_EN
    assign o_Frame_Count = fcount_q;
`endif

endmodule
